// File: rtl/load_store_unit.sv
// Load/store sequencer for a word-wide memory: byte/halfword/word loads with
// lane extraction and extension, sub-word stores via read-modify-write.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_is_store,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [31:0]           i_store_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fault,
  output logic [31:0]           o_load_data,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [31:0]           o_mem_write_data,
  output logic                  o_mem_writeEn,
  input  logic [31:0]           i_mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE,
    S_RESP,
    S_FAULT
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_load_data;
  logic                  w_illegal;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_value;
  logic [31:0]           w_merged;

  // Classification uses the raw request inputs since it happens at acceptance.
  always_comb begin
    w_illegal = 1'b0;
    if (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111)
      w_illegal = 1'b1;
    if (i_is_store && i_funct3[2])
      w_illegal = 1'b1;
    if (i_funct3[1:0] == 2'b01 && i_address[0])
      w_illegal = 1'b1;
    if (i_funct3 == 3'b010 && i_address[1:0] != 2'b00)
      w_illegal = 1'b1;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_illegal)                 w_next_state = S_FAULT;
          else if (!i_is_store)          w_next_state = S_LOAD;
          else if (i_funct3 == 3'b010)   w_next_state = S_WRITE;
          else                           w_next_state = S_RMW_READ;
        end
      end
      S_LOAD:     w_next_state = S_RESP;
      S_RMW_READ: w_next_state = S_WRITE;
      S_WRITE:    w_next_state = S_RESP;
      S_RESP:     w_next_state = S_IDLE;
      S_FAULT:    w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = i_mem_read_data[7:0];
      2'd1:    w_byte = i_mem_read_data[15:8];
      2'd2:    w_byte = i_mem_read_data[23:16];
      default: w_byte = i_mem_read_data[31:24];
    endcase
    w_half = r_addr[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];
    case (r_funct3)
      3'b000:  w_load_value = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_value = {24'd0, w_byte};
      3'b001:  w_load_value = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_value = {16'd0, w_half};
      default: w_load_value = i_mem_read_data;
    endcase
  end

  // Until the merge, r_wdata still holds the latched store operand.
  always_comb begin
    w_merged = i_mem_read_data;
    if (!r_funct3[0]) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_load_data <= 32'd0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_funct3 <= i_funct3;
        r_addr   <= i_address;
        r_wdata  <= i_store_data;
      end
      if (r_state == S_LOAD)
        r_load_data <= w_load_value;
      if (r_state == S_RMW_READ)
        r_wdata <= w_merged;
    end
  end

  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_RESP) || (r_state == S_FAULT);
  assign o_fault          = (r_state == S_FAULT);
  assign o_load_data      = r_load_data;
  assign o_mem_address    = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_write_data = r_wdata;
  // Reset gates the strobe so a reset landing on WRITE stores nothing.
  assign o_mem_writeEn    = (r_state == S_WRITE) && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_start;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_address;
  logic [31:0] i_store_data;
  logic        o_busy;
  logic        o_done;
  logic        o_fault;
  logic [31:0] o_load_data;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic        o_mem_writeEn;
  logic [31:0] i_mem_read_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int write_count  = 0;

  logic [31:0] tb_mem [256];
  logic [7:0]  ref_bytes [1024];
  logic [31:0] exp_load_data;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .i_start          (i_start),
    .i_is_store       (i_is_store),
    .i_funct3         (i_funct3),
    .i_address        (i_address),
    .i_store_data     (i_store_data),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_fault          (o_fault),
    .o_load_data      (o_load_data),
    .o_mem_address    (o_mem_address),
    .o_mem_write_data (o_mem_write_data),
    .o_mem_writeEn    (o_mem_writeEn),
    .i_mem_read_data  (i_mem_read_data)
  );

  assign i_mem_read_data = tb_mem[o_mem_address[9:2]];

  always @(posedge clock) begin
    if (o_mem_writeEn) begin
      tb_mem[o_mem_address[9:2]] <= o_mem_write_data;
      write_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int base;
    base = a - (a % 4);
    return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
  endfunction

  function automatic bit ref_illegal(input bit st, input logic [2:0] f3, input int a);
    int nbytes;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (st && (f3 == 4 || f3 == 5)) return 1'b1;
    nbytes = (f3 == 2) ? 4 : ((f3 == 1 || f3 == 5) ? 2 : 1);
    return (a % nbytes) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    byte     sb;
    shortint sh;
    case (f3)
      3'd0: begin sb = byte'(ref_bytes[a]); return 32'(int'(sb)); end
      3'd4: return 32'(ref_bytes[a]);
      3'd1: begin sh = shortint'({ref_bytes[a+1], ref_bytes[a]}); return 32'(int'(sh)); end
      3'd5: return 32'({ref_bytes[a+1], ref_bytes[a]});
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] d);
    int n;
    n = (f3 == 2) ? 4 : ((f3 == 1) ? 2 : 1);
    for (int k = 0; k < n; k++) ref_bytes[a+k] = d[8*k +: 8];
  endtask

  // Called at a falling edge; returns at the falling edge after the done cycle.
  task automatic run_req(input bit st, input logic [2:0] f3, input int a,
                         input logic [31:0] d, input bit poke);
    bit illegal;
    int exp_lat, exp_writes, cycles, w0;
    illegal    = ref_illegal(st, f3, a);
    exp_lat    = illegal ? 1 : (!st ? 2 : (f3 == 2 ? 2 : 3));
    exp_writes = (st && !illegal) ? 1 : 0;
    w0 = write_count;
    i_start = 1'b1; i_is_store = st; i_funct3 = f3;
    i_address = 32'(a); i_store_data = d;
    @(negedge clock);
    i_start = 1'b0;
    cycles = 1;
    check("busy_after_start", 32'(o_busy), 32'd1);
    if (poke && !o_done) begin
      i_start = 1'b1; i_is_store = 1'b1; i_funct3 = 3'b010;
      i_address = 32'(a ^ 4); i_store_data = ~d;
    end
    while (!o_done && cycles < 10) begin
      @(negedge clock);
      i_start = 1'b0;
      cycles++;
    end
    if (!illegal) begin
      if (st) ref_store(f3, a, d);
      else    exp_load_data = ref_load(f3, a);
    end
    check("latency", 32'(cycles), 32'(exp_lat));
    check("fault", 32'(o_fault), 32'(illegal));
    check("load_data", o_load_data, exp_load_data);
    @(negedge clock);
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("write_count", 32'(write_count - w0), 32'(exp_writes));
    check("mem_word", tb_mem[a/4], ref_word(a));
    $display("[TB] %s f3=%0d addr=%03h data=%08h lat=%0d fault=%0b load=%08h",
             st ? "ST" : "LD", f3, a, d, cycles, o_fault, o_load_data);
  endtask

  initial begin
    int w0;
    reset = 1'b1; i_start = 1'b0; i_is_store = 1'b0; i_funct3 = 3'd0;
    i_address = 32'd0; i_store_data = 32'd0;
    exp_load_data = 32'd0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'($urandom);
    ref_bytes[16'h40] = 8'hBB; ref_bytes[16'h41] = 8'hAA;
    ref_bytes[16'h42] = 8'h99; ref_bytes[16'h43] = 8'h88;
    for (int i = 0; i < 256; i++)
      tb_mem[i] = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_load_data", o_load_data, 32'd0);
    check("rst_mem_address", o_mem_address, 32'd0);
    check("rst_mem_write_data", o_mem_write_data, 32'd0);
    check("rst_mem_writeEn", 32'(o_mem_writeEn), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_req(1'b0, 3'b010, 'h40, 32'd0, 1'b0);
    check("lw_0x40", o_load_data, 32'h8899AABB);
    run_req(1'b0, 3'b000, 'h41, 32'd0, 1'b0);
    check("lb_0x41", o_load_data, 32'hFFFFFFAA);
    run_req(1'b0, 3'b100, 'h41, 32'd0, 1'b0);
    check("lbu_0x41", o_load_data, 32'h000000AA);
    run_req(1'b0, 3'b001, 'h42, 32'd0, 1'b0);
    check("lh_0x42", o_load_data, 32'hFFFF8899);
    run_req(1'b0, 3'b101, 'h42, 32'd0, 1'b0);
    check("lhu_0x42", o_load_data, 32'h00008899);
    run_req(1'b1, 3'b000, 'h42, 32'h12345677, 1'b1);
    check("sb_mem", tb_mem['h10], 32'h8877AABB);
    run_req(1'b0, 3'b010, 'h40, 32'd0, 1'b0);
    check("lw_after_sb", o_load_data, 32'h8877AABB);
    run_req(1'b1, 3'b001, 'h43, 32'hDEADBEEF, 1'b0);
    run_req(1'b0, 3'b010, 'h42, 32'd0, 1'b0);
    run_req(1'b1, 3'b100, 'h40, 32'hCAFEF00D, 1'b0);
    check("fault_keeps_load", o_load_data, 32'h8877AABB);

    // Reset landing on the WRITE cycle of an SH must not store.
    w0 = write_count;
    i_start = 1'b1; i_is_store = 1'b1; i_funct3 = 3'b001;
    i_address = 32'h44; i_store_data = 32'h0000BEEF;
    @(negedge clock);
    i_start = 1'b0;
    @(negedge clock);
    check("sh_write_cycle", 32'(o_mem_writeEn), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_gates_writeEn", 32'(o_mem_writeEn), 32'd0);
    @(negedge clock);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_load_data", o_load_data, 32'd0);
    check("midrst_mem_address", o_mem_address, 32'd0);
    check("midrst_mem_write_data", o_mem_write_data, 32'd0);
    check("midrst_writes", 32'(write_count - w0), 32'd0);
    check("midrst_mem_word", tb_mem['h11], ref_word('h44));
    reset = 1'b0;
    exp_load_data = 32'd0;
    @(negedge clock);

    for (int n = 0; n < 200; n++) begin
      run_req(1'($urandom), 3'($urandom), int'($urandom_range(0, 1019)),
              $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
